// File: rtl/fb_read_arbiter_pkg.sv
// Shared types for the framebuffer port arbiters: owner and state encodings, address-width helper.
package fb_read_arbiter_pkg;

    localparam int c_stall_w = 16;

    typedef enum logic {
        OWN_DRV = 1'b0,
        OWN_ANI = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRV  = 2'd1,
        S_ANI  = 2'd2
    } state_e;

    // 32 channels per LED board; address covers every channel in the chain.
    function automatic int f_addr_w(input int ledboards);
        return $clog2(ledboards * 32);
    endfunction

endpackage

// File: rtl/fb_rd_pipe.sv
// Carries {valid, owner} of each granted read through the framebuffer read latency.
// Synchronous clear drops every in-flight read.
module fb_rd_pipe
    import fb_read_arbiter_pkg::*;
#(
    parameter int c_rd_lat = 1
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_vld,
    input  owner_e i_own,
    output logic   o_vld,
    output owner_e o_own
);

    logic   [c_rd_lat-1:0] r_vld;
    owner_e                r_own [c_rd_lat];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int k = 1; k < c_rd_lat; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    // Owner is only qualified by the valid bit, so it needs no reset.
    always_ff @(posedge i_clk) begin
        r_own[0] <= i_own;
        for (int k = 1; k < c_rd_lat; k++) begin
            r_own[k] <= r_own[k-1];
        end
    end

    assign o_vld = r_vld[c_rd_lat-1];
    assign o_own = r_own[c_rd_lat-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Arbitrates the current-framebuffer read port between driver and animator with bounded bursts.
// Optional stall counters under FB_ARB_STATS_EN.
module fb_read_arbiter
    import fb_read_arbiter_pkg::*;
#(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_rd_lat    = 1,
    parameter int c_max_burst = 32,
    parameter int c_addr_w    = f_addr_w(c_ledboards)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_drv_req,
    input  logic [c_addr_w-1:0] i_drv_addr,
    output logic                o_drv_gnt,
    output logic                o_drv_rvalid,
    output logic [c_bpc-1:0]    o_drv_rdata,
    input  logic                i_ani_req,
    input  logic [c_addr_w-1:0] i_ani_addr,
    output logic                o_ani_gnt,
    output logic                o_ani_rvalid,
    output logic [c_bpc-1:0]    o_ani_rdata,
`ifdef FB_ARB_STATS_EN
    input  logic                i_stats_clr,
    output logic [c_stall_w-1:0] o_stall_drv,
    output logic [c_stall_w-1:0] o_stall_ani,
`endif
    output logic [c_addr_w-1:0] o_fb_raddr,
    input  logic [c_bpc-1:0]    i_fb_rdata
);

    localparam int                c_cnt_w   = $clog2(c_max_burst + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(c_max_burst);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    state_e               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 w_gnt_drv, w_gnt_ani;
    logic                 w_drv_yield, w_ani_yield;
    logic                 w_pipe_vld;
    owner_e               w_pipe_own;

    assign w_drv_yield = i_ani_req && (r_cnt >= c_max_cnt);
    assign w_ani_yield = i_drv_req && (r_cnt >= c_max_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_gnt_drv   = 1'b0;
        w_gnt_ani   = 1'b0;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;

        case (r_state)
            S_DRV: begin
                if (i_drv_req && !w_drv_yield) w_gnt_drv = 1'b1;
                else if (i_ani_req)            w_gnt_ani = 1'b1;
            end
            S_ANI: begin
                if (i_ani_req && !w_ani_yield) w_gnt_ani = 1'b1;
                else if (i_drv_req)            w_gnt_drv = 1'b1;
            end
            default: begin
                if (i_drv_req)      w_gnt_drv = 1'b1;
                else if (i_ani_req) w_gnt_ani = 1'b1;
            end
        endcase

        // Nothing is granted while reset is held, so the port is quiet from the first reset cycle.
        if (i_rst) begin
            w_gnt_drv = 1'b0;
            w_gnt_ani = 1'b0;
        end

        // The count tracks how long the other side has been waiting behind the current owner.
        if (w_gnt_drv) begin
            w_state_nxt = S_DRV;
            if (i_ani_req) w_cnt_nxt = (r_state == S_DRV) ? r_cnt + c_one : c_one;
        end else if (w_gnt_ani) begin
            w_state_nxt = S_ANI;
            if (i_drv_req) w_cnt_nxt = (r_state == S_ANI) ? r_cnt + c_one : c_one;
        end
    end

    assign o_drv_gnt  = w_gnt_drv;
    assign o_ani_gnt  = w_gnt_ani;
    assign o_fb_raddr = w_gnt_drv ? i_drv_addr : (w_gnt_ani ? i_ani_addr : '0);

    fb_rd_pipe #(
        .c_rd_lat (c_rd_lat)
    ) u_rd_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_vld (w_gnt_drv || w_gnt_ani),
        .i_own (w_gnt_ani ? OWN_ANI : OWN_DRV),
        .o_vld (w_pipe_vld),
        .o_own (w_pipe_own)
    );

    assign o_drv_rvalid = w_pipe_vld && (w_pipe_own == OWN_DRV);
    assign o_ani_rvalid = w_pipe_vld && (w_pipe_own == OWN_ANI);
    assign o_drv_rdata  = i_fb_rdata;
    assign o_ani_rdata  = i_fb_rdata;

`ifdef FB_ARB_STATS_EN
    logic [c_stall_w-1:0] r_stall_drv, r_stall_ani;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stats_clr) begin
            r_stall_drv <= '0;
            r_stall_ani <= '0;
        end else begin
            if (i_drv_req && !w_gnt_drv && (r_stall_drv != '1)) r_stall_drv <= r_stall_drv + 1'b1;
            if (i_ani_req && !w_gnt_ani && (r_stall_ani != '1)) r_stall_ani <= r_stall_ani + 1'b1;
        end
    end

    assign o_stall_drv = r_stall_drv;
    assign o_stall_ani = r_stall_ani;
`endif

endmodule
